// File: rtl/vip_morph_pkg.sv
// Shared constants and helpers for the 3x3 binary morphology stage.
package vip_morph_pkg;

    localparam int unsigned MODE_ERODE    = 0;
    localparam int unsigned MODE_DILATE   = 1;
    localparam int unsigned IMG_W_MAX_DEF = 1024;
    localparam int unsigned COL_W         = $clog2(IMG_W_MAX_DEF);

    // Sync bundle carried alongside the pixel through the pipeline.
    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    // Padding value that leaves the window operation unaffected.
    function automatic logic neutral(input int unsigned mode);
        return (mode == MODE_ERODE) ? 1'b1 : 1'b0;
    endfunction

    function automatic int unsigned col_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/vip_bin_linebuf.sv
// Two-row 1-bit line store; rows not yet filled in this frame read as the neutral value.
module vip_bin_linebuf
    import vip_morph_pkg::*;
#(
    parameter int unsigned Depth   = 1024,
    parameter int unsigned AddrW   = 10,
    parameter logic        Neutral = 1'b1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic             din_i,
    input  logic [1:0]       row_i,
    output logic             buf1_o,
    output logic             buf2_o
);

    logic mem1_q [Depth];
    logic mem2_q [Depth];
    logic rd1;
    logic rd2;

    // Asynchronous read so the same column can be consumed and rewritten in one cycle.
    assign rd1 = mem1_q[addr_i];
    assign rd2 = mem2_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem2_q[addr_i] <= mem1_q[addr_i];
            mem1_q[addr_i] <= din_i;
        end
    end

    always_comb begin
        buf1_o = Neutral;
        buf2_o = Neutral;
        if (row_i >= 2'd1) begin
            buf1_o = rd1;
        end
        if (row_i >= 2'd2) begin
            buf2_o = rd2;
        end
    end

endmodule

// File: rtl/vip_bin_morph.sv
// 3x3 binary erosion/dilation on the 1-bit edge stream, fixed 2-clock latency on data and sync.
module vip_bin_morph
    import vip_morph_pkg::*;
#(
    parameter int unsigned IMG_W_MAX = 1024,
    parameter int unsigned MODE      = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre_frame_vsync,
    input  logic pre_frame_href,
    input  logic pre_frame_clken,
    input  logic pre_img_bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_bit
);

    localparam int unsigned     CW       = col_width(IMG_W_MAX);
    localparam logic            N        = neutral(MODE);
    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W_MAX - 1);
    localparam logic [8:0]      WIN_FILL = {9{N}};

    sync_t          sync_in;
    sync_t          sync_s1_q;
    sync_t          sync_s2_q;
    logic           href_rise;
    logic           href_fall;
    logic           vsync_rise;

    logic [CW-1:0]  col_q, col_d, col_eff;
    logic [1:0]     row_q, row_d, row_eff;
    logic           ovf_q, ovf_d, ovf_eff;
    logic           ovf_s1_q;
    logic [2:0][2:0] win_q, win_d, win_base;
    logic           buf1_bit;
    logic           buf2_bit;
    logic           morph;
    logic           bit_q, bit_d;

    assign sync_in    = {pre_frame_vsync, pre_frame_href, pre_frame_clken};
    assign href_rise  = pre_frame_href & ~sync_s1_q.href;
    assign href_fall  = ~pre_frame_href & sync_s1_q.href;
    assign vsync_rise = pre_frame_vsync & ~sync_s1_q.vsync;

    // Edge-triggered clears apply to the pixel arriving in the same cycle.
    always_comb begin
        col_eff  = href_rise ? '0 : col_q;
        ovf_eff  = href_rise ? 1'b0 : ovf_q;
        win_base = href_rise ? WIN_FILL : win_q;
        row_eff  = vsync_rise ? 2'd0 : row_q;
    end

    always_comb begin
        col_d = col_eff;
        ovf_d = ovf_eff;
        win_d = win_base;
        if (pre_frame_clken) begin
            if (col_eff == COL_LAST) begin
                ovf_d = 1'b1;
            end else begin
                col_d = col_eff + CW'(1);
            end
            // Column 0 is the newest; within a column bit 0 is the current row.
            win_d = {win_base[1], win_base[0], {buf2_bit, buf1_bit, pre_img_bit}};
        end
    end

    always_comb begin
        row_d = row_q;
        if (vsync_rise) begin
            row_d = 2'd0;
        end else if (href_fall && (row_q != 2'd3)) begin
            row_d = row_q + 2'd1;
        end
    end

    always_comb begin
        morph = (MODE == MODE_DILATE) ? (|win_q) : (&win_q);
        bit_d = sync_s1_q.clken & ~ovf_s1_q & morph;
    end

    vip_bin_linebuf #(
        .Depth   (IMG_W_MAX),
        .AddrW   (CW),
        .Neutral (N)
    ) u_linebuf (
        .clk    (clk),
        .we_i   (pre_frame_clken),
        .addr_i (col_eff),
        .din_i  (pre_img_bit),
        .row_i  (row_eff),
        .buf1_o (buf1_bit),
        .buf2_o (buf2_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1_q <= '0;
            sync_s2_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_s1_q  <= 1'b0;
            win_q     <= WIN_FILL;
            bit_q     <= 1'b0;
        end else begin
            sync_s1_q <= sync_in;
            sync_s2_q <= sync_s1_q;
            col_q     <= col_d;
            row_q     <= row_d;
            ovf_q     <= ovf_d;
            if (pre_frame_clken) begin
                ovf_s1_q <= ovf_eff;
            end
            win_q     <= win_d;
            bit_q     <= bit_d;
        end
    end

    assign post_frame_vsync = sync_s2_q.vsync;
    assign post_frame_href  = sync_s2_q.href;
    assign post_frame_clken = sync_s2_q.clken;
    assign post_img_bit     = bit_q;

endmodule

// File: tb/tb_vip_bin_morph.sv
// Self-checking bench: erosion and dilation instances driven in parallel against a window model.
module tb_vip_bin_morph;

    localparam int W_MAX = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic vsync = 1'b0;
    logic href  = 1'b0;
    logic clken = 1'b0;
    logic pix   = 1'b0;
    logic e_vs, e_hr, e_ck, e_bit;
    logic d_vs, d_hr, d_ck, d_bit;

    int cyc = 0;
    int errs = 0;
    int checks = 0;
    int zero_viol = 0;
    bit img [0:7][0:31];
    bit q_e[$];
    bit q_d[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vip_bin_morph #(.IMG_W_MAX(W_MAX), .MODE(0)) u_ero (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (vsync),
        .pre_frame_href   (href),
        .pre_frame_clken  (clken),
        .pre_img_bit      (pix),
        .post_frame_vsync (e_vs),
        .post_frame_href  (e_hr),
        .post_frame_clken (e_ck),
        .post_img_bit     (e_bit)
    );

    vip_bin_morph #(.IMG_W_MAX(W_MAX), .MODE(1)) u_dil (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (vsync),
        .pre_frame_href   (href),
        .pre_frame_clken  (clken),
        .pre_img_bit      (pix),
        .post_frame_vsync (d_vs),
        .post_frame_href  (d_hr),
        .post_frame_clken (d_ck),
        .post_img_bit     (d_bit)
    );

    always @(negedge clk) begin
        if (e_ck) q_e.push_back(e_bit); else if (e_bit) zero_viol++;
        if (d_ck) q_d.push_back(d_bit); else if (d_bit) zero_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output (r,c) = AND/OR over input rows r-2..r, cols c-2..c; outside the frame reads neutral.
    function automatic bit model(input int mode, input int r, input int c);
        bit n = (mode == 0);
        bit acc = n;
        bit v;
        if (c >= W_MAX) return 1'b0;
        for (int dr = -2; dr <= 0; dr++) begin
            for (int dc = -2; dc <= 0; dc++) begin
                v = (r + dr < 0 || c + dc < 0) ? n : img[r + dr][c + dc];
                acc = (mode == 1) ? (acc | v) : (acc & v);
            end
        end
        return acc;
    endfunction

    function automatic logic cur(input int sel);
        case (sel)
            0: return d_vs;
            1: return d_hr;
            2: return d_ck;
            default: return e_ck;
        endcase
    endfunction

    function automatic int ones(input int m);
        int n = 0;
        if (m == 1) begin
            foreach (q_d[i]) n += int'(q_d[i]);
        end else begin
            foreach (q_e[i]) n += int'(q_e[i]);
        end
        return n;
    endfunction

    // kind: 0 zeros, 1 ones, 2 single pixel at (5,5), 3 block 4..6, 4 random
    task automatic fill(input int kind);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                case (kind)
                    0: img[r][c] = 1'b0;
                    1: img[r][c] = 1'b1;
                    2: img[r][c] = (r == 5 && c == 5);
                    3: img[r][c] = (r >= 4 && r <= 6 && c >= 4 && c <= 6);
                    default: img[r][c] = ($urandom_range(0, 2) != 0);
                endcase
            end
        end
    endtask

    // Measures input-to-output delay of one sync transition; pulse mode drops clken after one clock.
    task automatic lat(input string tag, input int sel, input logic lvl, input bit pulse);
        int t0 = cyc;
        int seen = -1;
        int hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pulse && i == 1) clken = 1'b0;
            if (cur(sel) === lvl) hi++;
            if (seen < 0 && cur(sel) === lvl) seen = cyc - t0;
        end
        chk(tag, seen, 2);
        if (pulse) chk({tag, " width"}, hi, 1);
        tick();
    endtask

    task automatic send_line(input int r, input int w, input bit gaps);
        int c = 0;
        href = 1'b1;
        while (c < w) begin
            clken = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix = clken ? img[r][c] : 1'($urandom_range(0, 1));
            tick();
            if (clken) c++;
        end
        href = 1'b0;
        clken = 1'b0;
        pix = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int w, input int h, input bit gaps);
        q_e.delete();
        q_d.delete();
        vsync = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < h; r++) send_line(r, w, gaps);
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag, input int w, input int h, input bit hi_only);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s m%0d count", tag, m), (m == 1) ? q_d.size() : q_e.size(), w * h);
            if (((m == 1) ? q_d.size() : q_e.size()) == w * h) begin
                for (int r = 0; r < h; r++) begin
                    for (int c = 0; c < w; c++) begin
                        if (!hi_only || c >= W_MAX)
                            chk($sformatf("%s m%0d r%0d c%0d", tag, m, r, c),
                                (m == 1) ? int'(q_d[r * w + c]) : int'(q_e[r * w + c]),
                                int'(model(m, r, c)));
                    end
                end
            end
        end
        chk({tag, " idle data zero"}, zero_viol, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset vsync", d_vs, 0);
        chk("reset href", d_hr, 0);
        chk("reset clken", e_ck | d_ck, 0);
        chk("reset data", e_bit | d_bit, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Latency of every sync edge and a lone pixel.
        fill(1);
        q_e.delete();
        q_d.delete();
        vsync = 1'b1;
        lat("lat vsync rise", 0, 1'b1, 1'b0);
        href = 1'b1;
        lat("lat href rise", 1, 1'b1, 1'b0);
        clken = 1'b1;
        pix = 1'b1;
        lat("lat clken dil", 2, 1'b1, 1'b1);
        clken = 1'b1;
        lat("lat clken ero", 3, 1'b1, 1'b1);
        pix = 1'b0;
        href = 1'b0;
        lat("lat href fall", 1, 1'b0, 1'b0);
        vsync = 1'b0;
        lat("lat vsync fall", 0, 1'b0, 1'b0);
        chk("lone pixel dil", (q_d.size() > 0) ? int'(q_d[0]) : -1, int'(model(1, 0, 0)));
        chk("lone pixel ero", (q_e.size() > 0) ? int'(q_e[0]) : -1, int'(model(0, 0, 0)));
        repeat (3) tick();

        fill(2);
        send_frame(16, 8, 1'b0);
        check_frame("single", 16, 8, 1'b0);
        chk("single dil ones", ones(1), 9);

        fill(3);
        send_frame(16, 8, 1'b1);
        check_frame("block", 16, 8, 1'b0);
        chk("block ero ones", ones(0), 1);
        chk("block ero centre", (q_e.size() == 128) ? int'(q_e[6 * 16 + 6]) : -1, 1);

        fill(1);
        send_frame(16, 8, 1'b0);
        check_frame("ones", 16, 8, 1'b0);
        chk("ones ero count", ones(0), 128);

        fill(0);
        send_frame(16, 8, 1'b1);
        check_frame("zeros", 16, 8, 1'b0);
        chk("zeros dil count", ones(1), 0);

        // Back-to-back: heavy bottom rows, then an empty frame.
        fill(4);
        for (int c = 0; c < 32; c++) begin
            img[6][c] = 1'b1;
            img[7][c] = 1'b1;
        end
        send_frame(16, 8, 1'b1);
        check_frame("b2b f1", 16, 8, 1'b0);
        fill(0);
        send_frame(16, 8, 1'b0);
        check_frame("b2b f2", 16, 8, 1'b0);
        chk("b2b f2 dil ones", ones(1), 0);

        fill(4);
        send_frame(16, 6, 1'b1);
        check_frame("rand", 16, 6, 1'b0);

        // Lines wider than the buffer: the extra pixels must come out as 0.
        fill(1);
        send_frame(18, 4, 1'b1);
        check_frame("wide", 18, 4, 1'b1);

        // Reset in the middle of row 3.
        fill(2);
        vsync = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < 3; r++) send_line(r, 16, 1'b0);
        href = 1'b1;
        clken = 1'b1;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst vsync", d_vs | e_vs, 0);
        chk("midrst href", d_hr | e_hr, 0);
        chk("midrst clken", d_ck | e_ck, 0);
        chk("midrst data", d_bit | e_bit, 0);
        chk("midrst col", int'(u_dil.col_q), 0);
        chk("midrst row", int'(u_dil.row_q), 0);
        chk("midrst win dil", int'(u_dil.win_q), 0);
        chk("midrst win ero", int'(u_ero.win_q), 511);
        vsync = 1'b0;
        href = 1'b0;
        clken = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        send_frame(16, 8, 1'b0);
        check_frame("post rst", 16, 8, 1'b0);
        chk("post rst dil ones", ones(1), 9);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
